inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 22 ++
 rtl/inst_fifo.sv | 74 +++++++
 rtl/inst_fetch.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and widths for the instruction fetch unit and its prefetch buffer.
package inst_fetch_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + 8'd1;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Prefetch buffer: DEPTH entries of {inst, pc}; flush empties it, a same-cycle push and pop both land.
module inst_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  fetch_entry_t                   din,
    output fetch_entry_t                   dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH + 1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            push_s;
    logic            pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign empty  = (count_r == {CW{1'b0}});
    assign full   = (count_r == CW'(DEPTH));
    assign count  = count_r;
    assign dout   = mem_r[rd_ptr_r];
    assign pop_s  = pop && !empty;
    // a full buffer still accepts a write when the head leaves in the same cycle
    assign push_s = push && (!full || pop_s);

    // storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {(ADDR_W + DATA_W){1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues program memory reads into a prefetch buffer and
// presents the oldest buffered instruction to the control unit, with jump redirect.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_addr
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e      state_r;
    fetch_state_e      state_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_s;
    logic              req_r;
    logic              push_s;
    logic              pop_s;
    logic              flush_s;
    logic              full_s;
    logic              empty_s;
    logic              slot_free_s;
    logic [CW-1:0]     count_s;
    fetch_entry_t      wr_entry_s;
    fetch_entry_t      head_s;

    assign pop_s       = !empty_s && inst_ready;
    // a slot is still free after this write once a same-cycle pop is counted
    assign slot_free_s = (int'(count_s) + 1 - int'(pop_s)) < DEPTH;
    assign wr_entry_s  = {mem_data, addr_r};

    inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .din   (wr_entry_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // next-state, fetch PC, request address and buffer control
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        addr_s  = addr_r;
        push_s  = 1'b0;
        flush_s = jmp;
        case (state_r)
            ST_IDLE: begin
                if (jmp) begin
                    pc_s    = jmp_addr;
                    addr_s  = jmp_addr;
                    state_s = ST_REQ;
                end else if (!full_s) begin
                    addr_s  = pc_r;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (jmp) begin
                    pc_s = jmp_addr;
                    if (mem_ack) begin
                        addr_s  = jmp_addr;
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_DISCARD;
                    end
                end else if (mem_ack) begin
                    push_s  = 1'b1;
                    pc_s    = pc_inc(pc_r);
                    addr_s  = pc_inc(pc_r);
                    state_s = slot_free_s ? ST_REQ : ST_IDLE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_DISCARD: begin
                // pc_r holds the redirect target while the stale read drains
                if (jmp) begin
                    pc_s = jmp_addr;
                end else begin
                    pc_s = pc_r;
                end
                if (mem_ack) begin
                    addr_s  = jmp ? jmp_addr : pc_r;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_DISCARD;
                end
            end
            default: begin
                state_s = ST_IDLE;
                pc_s    = RESET_PC;
                addr_s  = RESET_PC;
            end
        endcase
    end

    // fetch state, PC and registered memory request outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_PC;
            addr_r  <= RESET_PC;
            req_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            addr_r  <= addr_s;
            req_r   <= (state_s != ST_IDLE);
        end
    end

    assign mem_req    = req_r;
    assign mem_addr   = addr_r;
    assign inst_valid = !empty_s;
    assign inst       = head_s.inst;
    assign inst_pc    = head_s.pc;

endmodule
